// File: rtl/rover_display_pkg.sv
// rover_display_pkg: shared state encoding and field widths for the rover display path.
package rover_display_pkg;
    typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;
    localparam int LOC_W            = 12;
    localparam int ORIENT_W         = 6;
    localparam int CMD_W            = 12;
    localparam int ORIENT_STEPS_DEF = 36;
endpackage

// File: rtl/vsync_edge_detect.sv
// vsync_edge_detect: one-cycle pulse on the falling edge of active-low vsync.
module vsync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic i_vsync,
    output logic o_fe
);
    logic r_vsync_q;
    // Resetting high means a vsync already low at reset release is not an edge.
    always_ff @(posedge clk)
        if (reset) r_vsync_q <= 1'b1;
        else       r_vsync_q <= i_vsync;
    assign o_fe = !i_vsync && r_vsync_q;
endmodule

// File: rtl/rover_frame_latch.sv
// rover_frame_latch: buffers rover state words and commits them at vsync start.
// Optional stale tracking enabled by defining ROVER_FRAME_LATCH_STALE_EN.
module rover_frame_latch
    import rover_display_pkg::*;
#(
    parameter int               STALE_FRAMES   = 60,
    parameter int               ORIENT_STEPS   = ORIENT_STEPS_DEF,
    parameter logic [LOC_W-1:0] RESET_LOCATION = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                vsync,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LOC_W-1:0]    in_location,
    input  logic [ORIENT_W-1:0] in_orientation,
    input  logic [CMD_W-1:0]    in_move_command,
    output logic [LOC_W-1:0]    location,
    output logic [ORIENT_W-1:0] orientation,
    output logic [CMD_W-1:0]    move_command,
    output logic                new_data,
    output logic                stale,
    output logic [7:0]          overwrite_count,
    output logic [7:0]          reject_count
);
    if (STALE_FRAMES < 1 || STALE_FRAMES > 255) begin : g_bad_stale
        $error("STALE_FRAMES must be in 1..255");
    end

    state_t                r_state, w_next;
    logic                  w_fe, w_acc, w_ok, w_rej, w_bypass, w_flush, w_load;
    logic [LOC_W-1:0]      r_buf_loc, r_location;
    logic [ORIENT_W-1:0]   r_buf_ori, r_orientation;
    logic [CMD_W-1:0]      r_buf_cmd, r_move_command;
    logic [7:0]            r_ovr, r_rej;

    vsync_edge_detect u_edge (
        .clk     (clk),
        .reset   (reset),
        .i_vsync (vsync),
        .o_fe    (w_fe)
    );

    assign in_ready = !reset && r_state != COMMIT;

    always_comb begin
        w_acc    = in_valid && in_ready;
        w_ok     = w_acc && int'(in_orientation) < ORIENT_STEPS;
        w_rej    = w_acc && !w_ok;
        w_bypass = w_ok && w_fe;
        w_flush  = w_fe && r_state == PENDING && !w_bypass;
        w_load   = w_ok && !w_fe;
        w_next   = r_state == COMMIT        ? IDLE    :
                   (w_bypass || w_flush)    ? COMMIT  :
                   w_load                   ? PENDING : r_state;
    end

    always_ff @(posedge clk)
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf_loc      <= '0;
            r_buf_ori      <= '0;
            r_buf_cmd      <= '0;
            r_location     <= RESET_LOCATION;
            r_orientation  <= '0;
            r_move_command <= '0;
            r_ovr          <= '0;
            r_rej          <= '0;
        end else begin
            if (w_load) begin
                r_buf_loc <= in_location;
                r_buf_ori <= in_orientation;
                r_buf_cmd <= in_move_command;
            end
            if (w_load && r_state == PENDING && r_ovr != 8'hFF) r_ovr <= r_ovr + 8'd1;
            if (w_rej && r_rej != 8'hFF) r_rej <= r_rej + 8'd1;
            // A word arriving on the frame edge goes straight out; any pending word is dropped.
            if (w_bypass) begin
                r_location     <= in_location;
                r_orientation  <= in_orientation;
                r_move_command <= in_move_command;
            end else if (w_flush) begin
                r_location     <= r_buf_loc;
                r_orientation  <= r_buf_ori;
                r_move_command <= r_buf_cmd;
            end
        end
    end

    assign location        = r_location;
    assign orientation     = r_orientation;
    assign move_command    = r_move_command;
    assign new_data        = r_state == COMMIT;
    assign overwrite_count = r_ovr;
    assign reject_count    = r_rej;

`ifdef ROVER_FRAME_LATCH_STALE_EN
    logic [7:0] r_stale_cnt, w_stale_nxt;
    logic       r_stale;
    assign w_stale_nxt = r_state == COMMIT ? 8'd0 :
                         (w_fe && !(w_bypass || w_flush) && r_stale_cnt != 8'hFF) ? r_stale_cnt + 8'd1 :
                         r_stale_cnt;
    // Registered from the next count so stale follows the threshold edge by one cycle.
    always_ff @(posedge clk)
        if (reset) begin
            r_stale_cnt <= '0;
            r_stale     <= 1'b0;
        end else begin
            r_stale_cnt <= w_stale_nxt;
            r_stale     <= int'(w_stale_nxt) >= STALE_FRAMES;
        end
    assign stale = r_stale;
`else
    assign stale = 1'b0;
`endif
endmodule

// File: tb/tb_rover_frame_latch.sv
// tb_rover_frame_latch: randomized scoreboard bench for rover_frame_latch.
module tb_rover_frame_latch;
    localparam int SF = 3;

    typedef struct {
        logic [11:0] loc;
        logic [5:0]  ori;
        logic [11:0] cmd;
    } word_t;

    logic        clk = 0, reset = 1, vsync = 1, in_valid = 0;
    logic [11:0] in_location = 0, in_move_command = 0;
    logic [5:0]  in_orientation = 0;
    logic        in_ready, new_data, stale;
    logic [11:0] location, move_command;
    logic [5:0]  orientation;
    logic [7:0]  overwrite_count, reject_count;

    rover_frame_latch #(.STALE_FRAMES(SF)) dut (
        .clk(clk), .reset(reset), .vsync(vsync), .in_valid(in_valid), .in_ready(in_ready),
        .in_location(in_location), .in_orientation(in_orientation), .in_move_command(in_move_command),
        .location(location), .orientation(orientation), .move_command(move_command),
        .new_data(new_data), .stale(stale), .overwrite_count(overwrite_count), .reject_count(reject_count)
    );

    always #5 clk = ~clk;

    int    n_vec = 0, n_err = 0;
    word_t exp_q[$];
    word_t m_pend, m_out;
    bit    m_pend_v = 0, m_commit = 0, m_prev_vs = 1, m_stale = 0;
    int    m_ovr = 0, m_rej = 0, m_sc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: one pending slot, commits pushed to the scoreboard queue.
    always @(posedge clk) begin
        bit fe, acc, legal, was, commit;
        word_t w;
        if (reset) begin
            m_pend_v = 0; m_commit = 0; m_prev_vs = 1; m_stale = 0;
            m_ovr = 0; m_rej = 0; m_sc = 0;
            m_out = '{12'h000, 6'd0, 12'h000};
            exp_q.delete();
        end else begin
            w = '{in_location, in_orientation, in_move_command};
            fe = !vsync && m_prev_vs;
            m_prev_vs = vsync;
            was = m_commit;
            commit = 0;
            acc = in_valid && !was;
            legal = in_orientation < 36;
            if (acc && !legal && m_rej < 255) m_rej++;
            if (!was) begin
                if (fe && acc && legal) begin
                    exp_q.push_back(w); m_pend_v = 0; commit = 1;
                end else if (fe && m_pend_v) begin
                    exp_q.push_back(m_pend); m_pend_v = 0; commit = 1;
                end else if (acc && legal) begin
                    if (m_pend_v && m_ovr < 255) m_ovr++;
                    m_pend = w; m_pend_v = 1;
                end
            end
            if (was) m_sc = 0;
            else if (fe && !commit && m_sc < 255) m_sc++;
`ifdef ROVER_FRAME_LATCH_STALE_EN
            m_stale = m_sc >= SF;
`else
            m_stale = 0;
`endif
            m_commit = commit;
        end
    end

    // Monitor: compares every cycle, pops the scoreboard on each commit strobe.
    always @(posedge clk) begin
        #1;
        chk("in_ready", in_ready, !reset && !m_commit);
        chk("new_data", new_data, m_commit);
        if (new_data && exp_q.size() > 0) m_out = exp_q.pop_front();
        chk("location", location, m_out.loc);
        chk("orientation", orientation, m_out.ori);
        chk("move_command", move_command, m_out.cmd);
        chk("overwrite_count", overwrite_count, m_ovr);
        chk("reject_count", reject_count, m_rej);
        chk("stale", stale, m_stale);
    end

    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [11:0] l, input logic [5:0] o, input logic [11:0] c);
        in_valid = 1; in_location = l; in_orientation = o; in_move_command = c;
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic frame();
        vsync = 0;
        repeat (3) @(negedge clk);
        vsync = 1;
        idle(3);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 0;
        idle(5);
        send(12'h1A5, 6'd9, 12'h030);
        idle(100);
        frame();
        send(12'h001, 6'd1, 12'h111);
        send(12'h002, 6'd2, 12'h222);
        idle(4);
        frame();
        send(12'h00E, 6'd3, 12'h333);
        idle(3);
        vsync = 0;
        send(12'h00F, 6'd4, 12'h444);
        idle(2);
        vsync = 1;
        idle(3);
        frame();
        send(12'h055, 6'd36, 12'h555);
        idle(2);
        frame();
        repeat (4) frame();
        send(12'h066, 6'd35, 12'h666);
        idle(2);
        frame();
        idle(4);
        for (int i = 0; i < 3000; i++) begin
            vsync = (i % 29) >= 2;
            in_valid = ($urandom % 4) == 0;
            in_location = 12'($urandom);
            in_orientation = 6'($urandom_range(0, 63));
            in_move_command = 12'($urandom);
            @(negedge clk);
        end
        vsync = 1;
        idle(4);
        send(12'h0AA, 6'd5, 12'h0BB);
        idle(2);
        reset = 1;
        @(negedge clk);
        reset = 0;
        idle(2);
        frame();
        idle(3);
        chk("drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rover_frame_latch.md
# rover_frame_latch

Frame-synchronous update stage directly upstream of the VGA display writer. Accepts rover state words (location, orientation, move command) from the measurement/command pipeline over a valid/ready handshake at any time. Holds the newest word in a pending buffer and commits it to the writer-facing registers only at the start of vertical sync, so a frame never tears. Commits are flagged by a one-cycle `new_data` pulse; overwrites, rejects and staleness are reported.

## Interface
- `STALE_FRAMES`, 60: consecutive frames without a commit before `stale` asserts; range 1..255.
- `ORIENT_STEPS`, 36: number of legal orientation codes; `in_orientation` values >= this are rejected.
- `RESET_LOCATION`, 12'h000: value of `location` after reset.

Ports:
- `clk`  in  1  65 MHz pixel clock, same domain as `vsync`.
- `reset`  in  1  synchronous, active-high.
- `vsync`  in  1  XVGA vertical sync, active low.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  block can accept a word.
- `in_location`  in  12  rover location.
- `in_orientation`  in  6  rover orientation code.
- `in_move_command`  in  12  move command.
- `location`  out  12  committed location.
- `orientation`  out  6  committed orientation.
- `move_command`  out  12  committed move command.
- `new_data`  out  1  one-cycle commit strobe.
- `stale`  out  1  no commit for `STALE_FRAMES` frames.
- `overwrite_count`  out  8  pending words replaced before commit, saturating.
- `reject_count`  out  8  words dropped for illegal orientation, saturating.

## Operation
- Frame edge (`fe`): `vsync` is 0 and the registered `vsync_q` is 1. `vsync_q` resets to 1, so a low `vsync` at reset release yields no edge.
- Accept (`acc`): `in_valid && in_ready`. `in_ready` = `!reset && state != COMMIT`.
- Accepted word with `in_orientation >= ORIENT_STEPS`: discarded and `reject_count` increments. The state is unchanged. It does not count as an overwrite.
- FSM states: IDLE (no pending word), PENDING (pending buffer full), COMMIT (one cycle, outputs loaded).
  - IDLE, legal `acc`, no `fe` -> PENDING; the buffer loads.
  - PENDING, legal `acc`, no `fe`: the buffer is replaced, `overwrite_count` increments, and the state stays PENDING.
  - PENDING, `fe` -> COMMIT; the output registers load from the buffer.
  - Any state except COMMIT, legal `acc` and `fe` in the same cycle -> COMMIT. The incoming word bypasses the buffer and loads the outputs directly. No overwrite is counted, even if a word was pending; the buffer is cleared.
  - IDLE, `fe` without a legal `acc`: stays IDLE and the outputs hold.
  - COMMIT -> IDLE unconditionally.
- `new_data` = 1 exactly in the COMMIT cycle.
- Stale counter: 8 bits.
  - Clears on entering COMMIT.
  - Increments on each `fe` that does not commit, saturating at 255.
  - `stale` = (counter >= `STALE_FRAMES`), registered.
- Counters saturate at 8'hFF and clear only on reset.
- Reset, including mid-PENDING: the pending word is lost. State IDLE, `location` = `RESET_LOCATION`, `orientation` 0, `move_command` 0, `new_data` 0, `stale` 0, both counts 0, `in_ready` 0.

## Timing
- Accept in cycle N: the word is pending from N+1. A word accepted in cycle N that coincides with `fe` appears on the outputs from N+1, with `new_data` high in N+1 only.
- `fe` in cycle N with a pending word: outputs update at N+1 and `new_data` is high at N+1 only. `in_ready` is low at N+1 and high at N+2.
- Latency from `vsync` falling to committed outputs: 1 clock. The outputs are stable well before the first active line.
- At most one commit per frame. The outputs change only in COMMIT cycles.
- `stale` updates one cycle after the `fe` that reaches the threshold. It drops at the COMMIT cycle +1.

## Configuration
- Macro `ROVER_FRAME_LATCH_STALE_EN`.
- Defined: the stale counter and the `stale` output are implemented as above.
- Undefined: the counter is not built, `stale` is tied to 0, and `STALE_FRAMES` is unused. All other behaviour is identical.

## Structure
- Package `rover_display_pkg` holds:
  - the state enum (IDLE/PENDING/COMMIT);
  - the field widths `LOC_W`=12, `ORIENT_W`=6, `CMD_W`=12;
  - the default `ORIENT_STEPS`=36.
- Sub-module `vsync_edge_detect`: registers `vsync` (reset value 1) and outputs the one-cycle `fe` pulse. It can be reused by other frame-synchronous stages.
- The rest is a single always block plus the counters.

## Test plan
- Reset, then hold `vsync` high and send no words -> all outputs at reset values, `location`=12'h000, `in_ready`=1 from the first cycle after reset.
- Accept {loc 12'h1A5, orient 9, cmd 12'h030}, then drop `vsync` 100 cycles later -> `new_data` is one pulse, 1 cycle after the edge, with `location`=12'h1A5 and `orientation`=9. `in_ready`=0 for that one cycle.
- Accept loc 12'h001, then 12'h002 before the frame edge -> commit shows 12'h002, `overwrite_count`=1.
- Accept loc 12'h00F in the same cycle as `fe` while 12'h00E is pending -> commit shows 12'h00F, `overwrite_count` unchanged, and the next `fe` produces no commit.
- Accept orient 36 -> word dropped, `reject_count`=1, and no `new_data` at the next edge.
- With the macro defined and `STALE_FRAMES`=3: send 3 frame edges with no words -> `stale`=1 after the third edge. A subsequent commit -> `stale`=0 one cycle later. Without the macro -> `stale` stays 0 throughout.
